spram_arbiter: RTL and testbench
================================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, RAM address width (64 locations).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_req  input  1  requester A access request, held until granted.
REQ-006 a_we  input  1  requester A write (1) / read (0).
REQ-007 a_addr  input  ADDR_W  requester A address.
REQ-008 a_wdata  input  DATA_W  requester A write data.
REQ-009 a_gnt  output  1  requester A access accepted this cycle.
REQ-010 a_rvalid  output  1  requester A read data valid, one-cycle pulse.
REQ-011 a_rdata  output  DATA_W  requester A read data.
REQ-012 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same directions, widths and meanings as the A signals, for requester B.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_data  output  DATA_W  RAM write data.
REQ-016 ram_out  input  DATA_W  RAM read data, valid the cycle after a read address is presented.
REQ-017 conflict_cnt  output  8  saturating count of cycles in which both requests were asserted.

Function
REQ-018 a_gnt and b_gnt shall be combinational from the requests and the priority register, and shall never both be 1.
REQ-019 Only a_req=1: a_gnt=1. Only b_req=1: b_gnt=1. Neither request: both grants 0, ram_we=0.
REQ-020 Both requests: the requester not granted most recently shall win (round-robin).
REQ-021 last_gnt register: updated at each edge on which a grant is issued; holds its value otherwise.
REQ-022 In the grant cycle, ram_we, ram_addr and ram_data shall be driven combinationally from the granted requester's we, addr and wdata.
REQ-023 When no grant is issued: ram_we=0 and ram_addr holds its last driven value (registered copy), preventing spurious RAM address-register updates.
REQ-024 Write latency: data shall be in the RAM at the end of the grant cycle; no rvalid is generated for a write.
REQ-025 Read latency: rvalid shall be asserted for the granted requester exactly 2 cycles after the grant cycle, with rdata = ram_out as sampled at the end of grant+1.
REQ-026 Read pipeline: 2 stages, each holding valid and owner; one new access per cycle; back-to-back reads from either requester shall be fully pipelined.
REQ-027 Read at cycle G followed by a write to the same address at G+1 shall return the pre-write data.
REQ-028 rdata shall hold its last value when rvalid=0.
REQ-029 conflict_cnt shall increment on each edge with a_req=1 and b_req=1, and saturate at 255.

Reset
REQ-030 rst_n=0 shall immediately force a_gnt=b_gnt=0, ram_we=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, ram_addr=0, conflict_cnt=0, and last_gnt=B, so that A wins the first conflict.
REQ-031 Reads in flight at reset shall be discarded; no rvalid shall be asserted after reset release for an access issued before reset.
REQ-032 First grant shall be possible in the first cycle with rst_n=1.

Verification
REQ-033 After reset, A writes addr 5 = 0x3C, then A reads addr 5 -> a_gnt in each request cycle; a_rvalid 2 cycles after the read grant with a_rdata=0x3C; b_rvalid stays 0.
REQ-034 Both request reads continuously for 4 cycles -> grants A,B,A,B; rvalids follow with the same order and 2-cycle latency; conflict_cnt=4.
REQ-035 B reads addr 9 (holding 0x11) at cycle G, A writes addr 9 = 0x22 at G+1 -> b_rdata=0x11; a later read of addr 9 returns 0x22.
REQ-036 rst_n pulsed low one cycle after a read grant -> no rvalid afterwards; all outputs at their reset values during reset.
REQ-037 Both requests held asserted for 300 cycles -> conflict_cnt saturates at 255; grants strictly alternate.
REQ-038 Idle cycles between accesses -> ram_we=0 and ram_addr is stable; a_gnt=b_gnt=0.

Source files
------------

// File: rtl/spram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spram_arbiter
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access is accepted per cycle. Reads return through a two-stage pipeline
// that tracks which requester owns each access in flight.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata      requester A request (held until granted)
//   a_gnt                          A accepted this cycle (combinational)
//   a_rvalid/a_rdata               A read return, 2 cycles after the grant
//   b_*                            same set for requester B
//   ram_we/ram_addr/ram_data       RAM command (driven in the grant cycle)
//   ram_out                        RAM read data, valid the cycle after address
//   conflict_cnt                   saturating count of cycles with both requests
// -----------------------------------------------------------------------------
module spram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_out,
  output logic [7:0]        conflict_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // 1 = B was granted most recently (reset value, so A wins the first conflict)
  logic              r_last_b;
  logic [ADDR_W-1:0] r_addr_hold;
  logic              r_vld_p1;
  logic              r_own_p1;   // 1 = owned by B
  logic              r_vld_p2;
  logic              r_own_p2;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic [7:0]        r_cnt;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_rd_issue;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data;

  // Grant decision: gated by rst_n so grants drop the instant reset asserts.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && (!b_req || r_last_b)) begin
        w_a_gnt = 1'b1;
      end else if (b_req) begin
        w_b_gnt = 1'b1;
      end
    end
  end

  // RAM command mux; with no grant the address is parked on the last one used
  // so the RAM's internal address register does not see spurious changes.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = r_addr_hold;
    w_ram_data = '0;
    w_rd_issue = 1'b0;
    if (w_a_gnt) begin
      w_ram_we   = a_we;
      w_ram_addr = a_addr;
      w_ram_data = a_wdata;
      w_rd_issue = !a_we;
    end else if (w_b_gnt) begin
      w_ram_we   = b_we;
      w_ram_addr = b_addr;
      w_ram_data = b_wdata;
      w_rd_issue = !b_we;
    end
  end

  // ---- grant cycle: priority, address hold and conflict counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b    <= 1'b1;
      r_addr_hold <= '0;
      r_cnt       <= 8'd0;
    end else begin
      if (w_a_gnt || w_b_gnt) begin
        r_last_b    <= w_b_gnt;
        r_addr_hold <= w_ram_addr;
      end
      if (a_req && b_req) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  // ---- stage p1: read issued, RAM is fetching ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_own_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_issue;
      r_own_p1 <= w_b_gnt;
    end
  end

  // ---- stage p2: capture ram_out into the owner's data register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_own_p2  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_own_p2 <= r_own_p1;
      if (r_vld_p1) begin
        if (r_own_p1) begin
          r_b_rdata <= ram_out;
        end else begin
          r_a_rdata <= ram_out;
        end
      end
    end
  end

  assign a_gnt        = w_a_gnt;
  assign b_gnt        = w_b_gnt;
  assign ram_we       = w_ram_we;
  assign ram_addr     = w_ram_addr;
  assign ram_data     = w_ram_data;
  assign a_rvalid     = r_vld_p2 && !r_own_p2;
  assign b_rvalid     = r_vld_p2 && r_own_p2;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_spram_arbiter.sv
`timescale 1ns/1ps
// Testbench for spram_arbiter: a RAM model, a transaction-level reference
// model (shadow memory, pending-read list with due cycles), a vector table,
// hand-written corner sequences and a randomized phase.
module tb_spram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_data, ram_out;
  logic [AW-1:0] ram_addr;
  logic [7:0]    conflict_cnt;

  spram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_out(ram_out), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Synchronous single-port RAM: registered read of the presented address.
  logic [DW-1:0] mem [64];
  logic          ram_load = 1'b1;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_out <= mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int due; bit own_b; logic [7:0] data; } rd_t;
  rd_t           pend[$];
  bit            m_last_a;
  logic [AW-1:0] m_hold;
  int            m_cnt;
  logic [7:0]    m_mem [64];
  logic [7:0]    m_rd_a, m_rd_b;
  int            cyc = 0;
  bit            e_ga, e_gb;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_last_a = 1'b0;
    m_hold   = '0;
    m_cnt    = 0;
    m_rd_a   = '0;
    m_rd_b   = '0;
  endtask

  task automatic model_check();
    bit va = 1'b0, vb = 1'b0;
    bit ewe = 1'b0;
    logic [AW-1:0] eaddr = m_hold;
    e_ga = a_req && (!b_req || !m_last_a);
    e_gb = b_req && !e_ga;
    if (e_ga) begin ewe = a_we; eaddr = a_addr; end
    else if (e_gb) begin ewe = b_we; eaddr = b_addr; end
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].own_b) begin vb = 1'b1; m_rd_b = pend[i].data; end
        else begin va = 1'b1; m_rd_a = pend[i].data; end
      end
    end
    chk("a_gnt", 32'(a_gnt), 32'(e_ga));
    chk("b_gnt", 32'(b_gnt), 32'(e_gb));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    chk("ram_addr", 32'(ram_addr), 32'(eaddr));
    if (e_ga && a_we) chk("ram_data", 32'(ram_data), 32'(a_wdata));
    if (e_gb && b_we) chk("ram_data", 32'(ram_data), 32'(b_wdata));
    chk("a_rvalid", 32'(a_rvalid), 32'(va));
    chk("b_rvalid", 32'(b_rvalid), 32'(vb));
    chk("a_rdata", 32'(a_rdata), 32'(m_rd_a));
    chk("b_rdata", 32'(b_rdata), 32'(m_rd_b));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  endtask

  task automatic model_update();
    if (e_ga) begin
      if (a_we) m_mem[a_addr] = a_wdata;
      else pend.push_back('{cyc + 2, 1'b0, m_mem[a_addr]});
      m_last_a = 1'b1;
      m_hold   = a_addr;
    end else if (e_gb) begin
      if (b_we) m_mem[b_addr] = b_wdata;
      else pend.push_back('{cyc + 2, 1'b1, m_mem[b_addr]});
      m_last_a = 1'b0;
      m_hold   = b_addr;
    end
    if (a_req && b_req && m_cnt < 255) m_cnt++;
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    cyc++;
  endtask

  // ---------------- cycle helpers ----------------
  task automatic drive(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic begin_cycle(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    drive(ar, aw, aa, ad, br, bw, ba, bd);
    @(negedge clk);
    model_check();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    begin_cycle(ar, aw, aa, ad, br, bw, ba, bd);
    end_cycle();
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Called just after a rising edge. Requests are held high to show the
  // grants are forced off while reset is asserted.
  task automatic apply_reset(input int nedges);
    drive(1, 0, 6'd3, 8'h00, 1, 0, 6'd4, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    chk("rst_b_rdata", 32'(b_rdata), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    model_reset();
    repeat (nedges) @(posedge clk);
    #1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ar; bit aw; logic [AW-1:0] aa; logic [DW-1:0] ad;
    bit br; bit bw; logic [AW-1:0] ba; logic [DW-1:0] bd;
    bit ga; bit gb; bit we; bit rva; bit rvb;
    logic [DW-1:0] rda; logic [DW-1:0] rdb; logic [7:0] cnt;
  } vec_t;
  vec_t tbl [11];

  initial begin
    bit prev_a;

    // RAM initial contents: mem[i] = i*7+3 (1->0A, 2->11, 3->18, 4->1F)
    tbl[0]  = '{1,0,6'd1,8'h00, 1,0,6'd2,8'h00, 1,0,0, 0,0, 8'h00,8'h00,8'd0};
    tbl[1]  = '{1,0,6'd3,8'h00, 1,0,6'd2,8'h00, 0,1,0, 0,0, 8'h00,8'h00,8'd1};
    tbl[2]  = '{1,0,6'd3,8'h00, 1,0,6'd4,8'h00, 1,0,0, 1,0, 8'h0A,8'h00,8'd2};
    tbl[3]  = '{1,0,6'd5,8'h00, 1,0,6'd4,8'h00, 0,1,0, 0,1, 8'h0A,8'h11,8'd3};
    tbl[4]  = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 0,0,0, 1,0, 8'h18,8'h11,8'd4};
    tbl[5]  = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 0,0,0, 0,1, 8'h18,8'h1F,8'd4};
    tbl[6]  = '{1,1,6'd5,8'h3C, 0,0,6'd0,8'h00, 1,0,1, 0,0, 8'h18,8'h1F,8'd4};
    tbl[7]  = '{1,0,6'd5,8'h00, 0,0,6'd0,8'h00, 1,0,0, 0,0, 8'h18,8'h1F,8'd4};
    tbl[8]  = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 0,0,0, 0,0, 8'h18,8'h1F,8'd4};
    tbl[9]  = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 0,0,0, 1,0, 8'h3C,8'h1F,8'd4};
    tbl[10] = '{0,0,6'd0,8'h00, 0,0,6'd0,8'h00, 0,0,0, 0,0, 8'h3C,8'h1F,8'd4};

    for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
    model_reset();
    @(posedge clk);
    #1;
    ram_load = 1'b0;
    apply_reset(1);

    // Table: conflicting reads then A write/read of address 5
    for (int i = 0; i < 11; i++) begin
      begin_cycle(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad,
                  tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      chk("tbl_a_gnt", 32'(a_gnt), 32'(tbl[i].ga));
      chk("tbl_b_gnt", 32'(b_gnt), 32'(tbl[i].gb));
      chk("tbl_ram_we", 32'(ram_we), 32'(tbl[i].we));
      chk("tbl_a_rvalid", 32'(a_rvalid), 32'(tbl[i].rva));
      chk("tbl_b_rvalid", 32'(b_rvalid), 32'(tbl[i].rvb));
      chk("tbl_a_rdata", 32'(a_rdata), 32'(tbl[i].rda));
      chk("tbl_b_rdata", 32'(b_rdata), 32'(tbl[i].rdb));
      chk("tbl_cnt", 32'(conflict_cnt), 32'(tbl[i].cnt));
      end_cycle();
    end

    // Read followed by a write to the same address returns pre-write data
    cycle(0, 0, '0, '0, 1, 1, 6'd9, 8'h11);
    cycle(0, 0, '0, '0, 1, 0, 6'd9, 8'h00);
    cycle(1, 1, 6'd9, 8'h22, 0, 0, '0, '0);
    begin_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    chk("rw_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("rw_b_rdata", 32'(b_rdata), 32'h11);
    end_cycle();
    cycle(1, 0, 6'd9, 8'h00, 0, 0, '0, '0);
    idle();
    begin_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    chk("rw_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("rw_a_rdata", 32'(a_rdata), 32'h22);
    end_cycle();

    // Reset one cycle after a read grant discards the read
    cycle(1, 0, 6'd7, 8'h00, 0, 0, '0, '0);
    apply_reset(1);
    begin_cycle(1, 1, 6'h2A, 8'h5A, 0, 0, '0, '0);
    chk("post_rst_first_gnt", 32'(a_gnt), 32'd1);
    end_cycle();
    for (int i = 0; i < 3; i++) begin
      begin_cycle(0, 0, '0, '0, 0, 0, '0, '0);
      chk("idle_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("idle_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("idle_ram_we", 32'(ram_we), 32'd0);
      chk("idle_ram_addr", 32'(ram_addr), 32'h2A);
      chk("idle_gnts", 32'({a_gnt, b_gnt}), 32'd0);
      end_cycle();
    end

    // Saturation and strict alternation under permanent conflict
    @(posedge clk);
    #1;
    apply_reset(1);
    prev_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      begin_cycle(1, 0, 6'(i % 64), 8'h00, 1, 0, 6'((i + 7) % 64), 8'h00);
      chk("alt_one_hot", 32'(a_gnt ^ b_gnt), 32'd1);
      if (i == 0) chk("alt_first_a", 32'(a_gnt), 32'd1);
      else chk("alt_toggle", 32'(a_gnt), 32'(!prev_a));
      prev_a = a_gnt;
      end_cycle();
    end
    begin_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    chk("sat_cnt", 32'(conflict_cnt), 32'd255);
    end_cycle();
    idle();
    idle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
    end
    idle();
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
